mole_round_ctrl: RTL and testbench

Game-round controller that consumes the random target box (1–4) from the target generator and runs one whack-a-mole round at a time. Each round it:
- lights the chosen box;
- waits for a player hit or a timeout;
- updates score and lives.

It sits between the LFSR target path and the hit-detection / display logic, and ends the game when lives reach zero.

---
 rtl/mole_pkg.sv | 21 ++
 rtl/mole_round_ctrl_if.sv | 27 ++
 rtl/round_timer.sv | 27 ++
 rtl/mole_round_ctrl.sv | 136 +++++++++++++
 tb/tb_mole_round_ctrl.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mole_pkg.sv
// rtl/mole_pkg.sv - shared round states, box encodings and target sanitising for the mole game.
package mole_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    SHOW,
    GAP,
    OVER
  } state_t;

  localparam logic [2:0] BOX_NONE = 3'd0;
  localparam logic [2:0] BOX_MIN  = 3'd1;
  localparam logic [2:0] BOX_MAX  = 3'd4;

  // The target generator may hand over 0 or 5..7; those all land on box 1.
  function automatic logic [2:0] sanitize_box(input logic [2:0] box);
    return (box >= BOX_MIN && box <= BOX_MAX) ? box : BOX_MIN;
  endfunction

endpackage

// File: rtl/mole_round_ctrl_if.sv
// rtl/mole_round_ctrl_if.sv - player/target inputs and score/display outputs of the round controller.
interface mole_round_ctrl_if #(
  parameter int SCORE_W = 8
);

  logic               start;
  logic [2:0]         target_box;
  logic               hit_valid;
  logic [2:0]         hit_box;
  logic [2:0]         active_box;
  logic [SCORE_W-1:0] score;
  logic [1:0]         lives;
  logic               hit_pulse;
  logic               miss_pulse;
  logic               game_over;

  modport master (
    output start, target_box, hit_valid, hit_box,
    input  active_box, score, lives, hit_pulse, miss_pulse, game_over
  );

  modport slave (
    input  start, target_box, hit_valid, hit_box,
    output active_box, score, lives, hit_pulse, miss_pulse, game_over
  );

endinterface

// File: rtl/round_timer.sv
// rtl/round_timer.sv - loadable down-counter; expire flags the last enabled cycle of a loaded span.
module round_timer #(
  parameter int W = 8
) (
  input  logic         CLOCK_50,
  input  logic         reset_signal,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         enable,
  output logic         expire
);

  logic [W-1:0] count;

  always_ff @(posedge CLOCK_50 or posedge reset_signal) begin
    if (reset_signal)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (enable && count != '0)
      count <= count - W'(1);
  end

  // A span loaded with N expires on its N-th enabled cycle.
  assign expire = enable && (count == W'(1));

endmodule

// File: rtl/mole_round_ctrl.sv
// rtl/mole_round_ctrl.sv - whack-a-mole round controller; ROUND_SPEEDUP_EN shortens SHOW as the score rises.
module mole_round_ctrl
  import mole_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int MIN_TIMEOUT    = 10_000_000,
  parameter int STEP_CYCLES    = 1_000_000,
  parameter int GAP_CYCLES     = 12_500_000,
  parameter int LIVES          = 3,
  parameter int SCORE_W        = 8
) (
  input logic              CLOCK_50,
  input logic              reset_signal,
  mole_round_ctrl_if.slave bus
);

  localparam int                 TW         = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
  localparam logic [1:0]         LIVES_INIT = 2'(LIVES);

  if (MIN_TIMEOUT < 1 || MIN_TIMEOUT > TIMEOUT_CYCLES || STEP_CYCLES < 0 ||
      GAP_CYCLES < 1 || GAP_CYCLES > TIMEOUT_CYCLES) begin : g_bad_cfg
    $error("mole_round_ctrl: timing parameters out of range");
  end

  state_t             state_q, next_state;
  logic [2:0]         target_q, active_q;
  logic [SCORE_W-1:0] score_q;
  logic [1:0]         lives_q;
  logic               hit_q, miss_q, over_q;
  logic               game_start, hit_evt, miss_evt;
  logic               tmr_load, tmr_en, tmr_expire;
  logic [TW-1:0]      tmr_val, show_len;

`ifdef ROUND_SPEEDUP_EN
  logic [63:0] cut;
  // Wide arithmetic so a large score can never wrap the subtraction.
  always_comb begin
    cut = 64'(score_q) * 64'(STEP_CYCLES);
    if (cut + 64'(MIN_TIMEOUT) >= 64'(TIMEOUT_CYCLES))
      show_len = TW'(MIN_TIMEOUT);
    else
      show_len = TW'(64'(TIMEOUT_CYCLES) - cut);
  end
`else
  assign show_len = TW'(TIMEOUT_CYCLES);
`endif

  round_timer #(.W(TW)) u_timer (
    .CLOCK_50     (CLOCK_50),
    .reset_signal (reset_signal),
    .load         (tmr_load),
    .load_val     (tmr_val),
    .enable       (tmr_en),
    .expire       (tmr_expire)
  );

  always_ff @(posedge CLOCK_50 or posedge reset_signal) begin
    if (reset_signal) state_q <= IDLE;
    else              state_q <= next_state;
  end

  always_comb begin
    next_state = state_q;
    game_start = 1'b0;
    hit_evt    = 1'b0;
    miss_evt   = 1'b0;
    tmr_load   = 1'b0;
    tmr_en     = 1'b0;
    tmr_val    = TW'(GAP_CYCLES);
    case (state_q)
      IDLE, OVER: begin
        if (bus.start) begin
          game_start = 1'b1;
          next_state = ARM;
        end
      end
      ARM: begin
        tmr_load   = 1'b1;
        tmr_val    = show_len;
        next_state = SHOW;
      end
      SHOW: begin
        tmr_en = 1'b1;
        // A hit wins over an expiry landing in the same cycle.
        if (bus.hit_valid && bus.hit_box == target_q) hit_evt = 1'b1;
        else if (bus.hit_valid || tmr_expire)         miss_evt = 1'b1;
        if (hit_evt || miss_evt) begin
          tmr_load   = 1'b1;
          next_state = (miss_evt && lives_q <= 2'd1) ? OVER : GAP;
        end
      end
      GAP: begin
        tmr_en = 1'b1;
        if (tmr_expire) next_state = ARM;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset_signal) begin
    if (reset_signal) begin
      target_q <= BOX_NONE;
      active_q <= BOX_NONE;
      score_q  <= '0;
      lives_q  <= '0;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
      over_q   <= 1'b0;
    end else begin
      hit_q  <= hit_evt;
      miss_q <= miss_evt;
      over_q <= (next_state == OVER);
      if (game_start) begin
        score_q <= '0;
        lives_q <= LIVES_INIT;
      end
      if (hit_evt && score_q != SCORE_MAX) score_q <= score_q + SCORE_W'(1);
      if (miss_evt && lives_q != 2'd0)     lives_q <= lives_q - 2'd1;
      if (state_q == ARM) begin
        target_q <= sanitize_box(bus.target_box);
        active_q <= sanitize_box(bus.target_box);
      end else if (next_state != SHOW) begin
        active_q <= BOX_NONE;
      end
    end
  end

  assign bus.active_box = active_q;
  assign bus.score      = score_q;
  assign bus.lives      = lives_q;
  assign bus.hit_pulse  = hit_q;
  assign bus.miss_pulse = miss_q;
  assign bus.game_over  = over_q;

endmodule

// File: tb/tb_mole_round_ctrl.sv
// tb/tb_mole_round_ctrl.sv - self-checking bench for mole_round_ctrl against a round-level game model.
module tb_mole_round_ctrl;

  localparam int TIMEOUT_CYCLES = 10;
  localparam int MIN_TIMEOUT    = 4;
  localparam int STEP_CYCLES    = 2;
  localparam int GAP_CYCLES     = 4;
  localparam int LIVES          = 3;
  localparam int SCORE_W        = 8;

  localparam int P_IDLE = 0;
  localparam int P_ARM  = 1;
  localparam int P_SHOW = 2;
  localparam int P_GAP  = 3;
  localparam int P_OVER = 4;

  typedef struct packed {
    int phase;
    int elapsed;
    int tlen;
    int target;
    int score;
    int lives;
    int active;
    bit hit;
    bit miss;
    bit over;
  } model_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  model_t m;

  always #5 clk = ~clk;

  mole_round_ctrl_if #(.SCORE_W(SCORE_W)) bus ();

  mole_round_ctrl #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .MIN_TIMEOUT    (MIN_TIMEOUT),
    .STEP_CYCLES    (STEP_CYCLES),
    .GAP_CYCLES     (GAP_CYCLES),
    .LIVES          (LIVES),
    .SCORE_W        (SCORE_W)
  ) dut (
    .CLOCK_50     (clk),
    .reset_signal (rst),
    .bus          (bus)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int show_len(input int score);
`ifdef ROUND_SPEEDUP_EN
    int t;
    t = TIMEOUT_CYCLES - score * STEP_CYCLES;
    return (t < MIN_TIMEOUT) ? MIN_TIMEOUT : t;
`else
    return TIMEOUT_CYCLES + 0 * score;
`endif
  endfunction

  function automatic model_t model_next(input model_t cur, input logic st, input logic [2:0] tb,
                                        input logic hv, input logic [2:0] hb);
    model_t n;
    n = cur;
    n.hit  = 1'b0;
    n.miss = 1'b0;
    case (cur.phase)
      P_IDLE, P_OVER: begin
        if (st) begin
          n.phase = P_ARM;
          n.score = 0;
          n.lives = LIVES;
          n.over  = 1'b0;
        end
      end
      P_ARM: begin
        n.target  = (int'(tb) >= 1 && int'(tb) <= 4) ? int'(tb) : 1;
        n.active  = n.target;
        n.tlen    = show_len(cur.score);
        n.elapsed = 0;
        n.phase   = P_SHOW;
      end
      P_SHOW: begin
        n.elapsed = cur.elapsed + 1;
        if (hv && int'(hb) == cur.target) begin
          n.hit = 1'b1;
          if (cur.score < (1 << SCORE_W) - 1) n.score = cur.score + 1;
        end else if (hv || n.elapsed == cur.tlen) begin
          n.miss = 1'b1;
        end
        if (n.hit || n.miss) begin
          n.active  = 0;
          n.elapsed = 0;
          if (n.miss) n.lives = cur.lives - 1;
          if (n.lives == 0) begin
            n.phase = P_OVER;
            n.over  = 1'b1;
          end else begin
            n.phase = P_GAP;
          end
        end
      end
      P_GAP: begin
        n.elapsed = cur.elapsed + 1;
        if (n.elapsed == GAP_CYCLES) begin
          n.phase   = P_ARM;
          n.elapsed = 0;
        end
      end
      default: n.phase = P_IDLE;
    endcase
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= '0;
    else     m <= model_next(m, bus.start, bus.target_box, bus.hit_valid, bus.hit_box);
  end

  always @(negedge clk) begin
    chk("model_active_box", int'(bus.active_box), m.active);
    chk("model_score",      int'(bus.score),      m.score);
    chk("model_lives",      int'(bus.lives),      m.lives);
    chk("model_hit_pulse",  int'(bus.hit_pulse),  int'(m.hit));
    chk("model_miss_pulse", int'(bus.miss_pulse), int'(m.miss));
    chk("model_game_over",  int'(bus.game_over),  int'(m.over));
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strike(input logic [2:0] box);
    bus.hit_valid = 1'b1;
    bus.hit_box   = box;
    step(1);
    bus.hit_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish by 100000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.start      = 1'b0;
    bus.target_box = 3'd0;
    bus.hit_valid  = 1'b0;
    bus.hit_box    = 3'd0;
    #1 rst = 1'b1;
    step(2);
    chk("rst_active", int'(bus.active_box), 0);
    chk("rst_score",  int'(bus.score),      0);
    chk("rst_lives",  int'(bus.lives),      0);
    chk("rst_hit",    int'(bus.hit_pulse),  0);
    chk("rst_miss",   int'(bus.miss_pulse), 0);
    chk("rst_over",   int'(bus.game_over),  0);
    #2 rst = 1'b0;

    // Correct hit on SHOW cycle 5.
    step(1);
    bus.start = 1'b1; bus.target_box = 3'd3;
    step(1);
    chk("arm_lives", int'(bus.lives), 3);
    chk("arm_active", int'(bus.active_box), 0);
    bus.start = 1'b0;
    step(1);
    chk("show_active", int'(bus.active_box), 3);
    step(4);
    bus.target_box = 3'd2;
    strike(3'd3);
    chk("hit_pulse", int'(bus.hit_pulse), 1);
    chk("hit_score", int'(bus.score), 1);
    chk("hit_lives", int'(bus.lives), 3);
    chk("hit_dark",  int'(bus.active_box), 0);
    step(1);
    chk("hit_pulse_one", int'(bus.hit_pulse), 0);
    step(3);
    chk("gap_dark", int'(bus.active_box), 0);
    step(1);
    chk("rearm_active", int'(bus.active_box), 2);

    // Wrong hit, then a timed-out round.
    strike(3'd4);
    chk("wrong_miss",  int'(bus.miss_pulse), 1);
    chk("wrong_lives", int'(bus.lives), 2);
    chk("wrong_score", int'(bus.score), 1);
    step(5);
    chk("to_active", int'(bus.active_box), 2);
    step(9);
    chk("to_early_miss", int'(bus.miss_pulse), 0);
    chk("to_early_active", int'(bus.active_box), 2);
    step(1);
    chk("to_miss",  int'(bus.miss_pulse), 1);
    chk("to_lives", int'(bus.lives), 1);
    chk("to_dark",  int'(bus.active_box), 0);

    // Correct hit landing on the expiry cycle.
    bus.target_box = 3'd4;
    step(5);
    chk("sim_active", int'(bus.active_box), 4);
    step(9);
    bus.target_box = 3'd0;
    strike(3'd4);
    chk("sim_hit",   int'(bus.hit_pulse), 1);
    chk("sim_miss",  int'(bus.miss_pulse), 0);
    chk("sim_score", int'(bus.score), 2);
    chk("sim_lives", int'(bus.lives), 1);

    // Target 0 sanitised, third miss ends the game.
    step(5);
    chk("sanitize_0", int'(bus.active_box), 1);
    step(10);
    chk("over_miss",  int'(bus.miss_pulse), 1);
    chk("over_lives", int'(bus.lives), 0);
    chk("over_flag",  int'(bus.game_over), 1);
    chk("over_dark",  int'(bus.active_box), 0);
    strike(3'd1);
    chk("over_ignore_hit",   int'(bus.hit_pulse), 0);
    chk("over_ignore_score", int'(bus.score), 2);
    chk("over_hold_flag",    int'(bus.game_over), 1);
    step(2);
    bus.start = 1'b1; bus.target_box = 3'd7;
    step(1);
    bus.start = 1'b0;
    chk("restart_score", int'(bus.score), 0);
    chk("restart_lives", int'(bus.lives), 3);
    chk("restart_over",  int'(bus.game_over), 0);
    step(1);
    chk("sanitize_7", int'(bus.active_box), 1);

    // Asynchronous reset in the middle of SHOW.
    step(3);
    #2 rst = 1'b1;
    #1;
    chk("arst_active", int'(bus.active_box), 0);
    chk("arst_lives",  int'(bus.lives), 0);
    chk("arst_score",  int'(bus.score), 0);
    step(1);
    chk("arst_hit",  int'(bus.hit_pulse), 0);
    chk("arst_miss", int'(bus.miss_pulse), 0);
    chk("arst_over", int'(bus.game_over), 0);
    #2 rst = 1'b0;

`ifdef ROUND_SPEEDUP_EN
    // Score 2 gives a 6-cycle SHOW, score 4 hits the 4-cycle floor.
    step(1);
    bus.start = 1'b1; bus.target_box = 3'd1;
    step(1);
    bus.start = 1'b0;
    step(1);
    strike(3'd1);
    step(5);
    strike(3'd1);
    chk("su_score2", int'(bus.score), 2);
    step(5);
    step(5);
    chk("su_len6_early", int'(bus.miss_pulse), 0);
    step(1);
    chk("su_len6", int'(bus.miss_pulse), 1);
    step(5);
    strike(3'd1);
    step(5);
    strike(3'd1);
    chk("su_score4", int'(bus.score), 4);
    step(5);
    step(3);
    chk("su_len4_early", int'(bus.miss_pulse), 0);
    step(1);
    chk("su_len4", int'(bus.miss_pulse), 1);
`endif

    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
